// File: rtl/popcount_window_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_window_accum_if
//  Purpose  : Sample input and window-result handshake bundle for the
//             popcount window accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
interface popcount_window_accum_if #(
  parameter int CNT_W = 6,
  parameter int SUM_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic [SUM_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_min;
  logic [CNT_W-1:0] out_max;
  logic             out_above;
  logic             dropped;

  modport master (
    output in_valid, in_cnt, thresh, out_ready,
    input  in_ready, out_valid, out_sum, out_min, out_max, out_above, dropped
  );

  modport slave (
    input  in_valid, in_cnt, thresh, out_ready,
    output in_ready, out_valid, out_sum, out_min, out_max, out_above, dropped
  );
endinterface
`default_nettype wire

// File: rtl/popcount_window_accum.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_window_accum
//  Purpose  : Accumulates WINDOW popcount samples into sum/min/max plus a
//             threshold flag, held behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_window_accum #(
  parameter int CNT_W  = 6,
  parameter int WINDOW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  popcount_window_accum_if.slave   bus
);
  localparam int SUM_W = CNT_W + $clog2(WINDOW);
  localparam int IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WINDOW - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_valid;
  logic             w_last;
  logic             w_first;
  logic [SUM_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_min_nxt;
  logic [CNT_W-1:0] w_max_nxt;

  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic [SUM_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_min;
  logic [CNT_W-1:0] r_out_max;
  logic             r_out_above;
  logic             r_dropped;

  assign w_out_valid = (r_state == ST_HOLD);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_first     = (r_idx == '0);
  assign w_last      = (r_idx == c_last_idx);
  assign w_acc_nxt   = r_acc + SUM_W'(bus.in_cnt);
  // The first sample of a window seeds min/max instead of comparing against stale values.
  assign w_min_nxt   = (w_first || (bus.in_cnt < r_min)) ? bus.in_cnt : r_min;
  assign w_max_nxt   = (w_first || (bus.in_cnt > r_max)) ? bus.in_cnt : r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    case (r_state)
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_in_fire && w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Accepting here is only safe because the held result leaves on this same edge.
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
    if (clr) begin
      w_state_nxt = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_out_sum   <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_out_above <= 1'b0;
      r_dropped   <= 1'b0;
    end else if (clr) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_out_sum   <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_out_above <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      if (bus.in_valid && !w_in_ready) begin
        r_dropped <= 1'b1;
      end
      if (w_in_fire) begin
        if (w_last) begin
          r_out_sum   <= w_acc_nxt;
          r_out_min   <= w_min_nxt;
          r_out_max   <= w_max_nxt;
          r_out_above <= (w_acc_nxt >= bus.thresh);
          r_idx       <= '0;
          r_acc       <= '0;
          r_min       <= '0;
          r_max       <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
          r_acc <= w_acc_nxt;
          r_min <= w_min_nxt;
          r_max <= w_max_nxt;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_min   = r_out_min;
  assign bus.out_max   = r_out_max;
  assign bus.out_above = r_out_above;
  assign bus.dropped   = r_dropped;
endmodule
`default_nettype wire

// File: tb/tb_popcount_window_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_popcount_window_accum
//  Purpose  : Scoreboard bench for popcount_window_accum (WINDOW=4 and 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_window_accum;
  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  popcount_window_accum_if #(.CNT_W(6), .SUM_W(8))  ia ();
  popcount_window_accum_if #(.CNT_W(6), .SUM_W(10)) ib ();

  popcount_window_accum #(.CNT_W(6), .WINDOW(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (ia.slave)
  );

  popcount_window_accum #(.CNT_W(6), .WINDOW(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (ib.slave)
  );

  typedef struct {
    logic [9:0] sum;
    logic [5:0] mn;
    logic [5:0] mx;
    logic       above;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c5[7]    = '{2, 63, 63, 4, 63, 6, 8};
  logic [6:0] pat5 = 7'b1101001;

  function automatic exp_t mk(input int s, input int mn, input int mx, input int ab);
    exp_t e;
    e.sum   = 10'(s);
    e.mn    = 6'(mn);
    e.mx    = 6'(mx);
    e.above = ab[0];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [5:0] c);
    ia.in_valid = 1'b1;
    ia.in_cnt   = c;
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [5:0] c);
    ib.in_valid = 1'b1;
    ib.in_cnt   = c;
    @(posedge clk);
    #1;
    ib.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected: got result sum %0d expected none", ia.out_sum);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_sum",   ia.out_sum,   e.sum);
        check("a_min",   ia.out_min,   e.mn);
        check("a_max",   ia.out_max,   e.mx);
        check("a_above", ia.out_above, e.above);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: got result sum %0d expected none", ib.out_sum);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_sum",   ib.out_sum,   e.sum);
        check("b_min",   ib.out_min,   e.mn);
        check("b_max",   ib.out_max,   e.mx);
        check("b_above", ib.out_above, e.above);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    ia.in_valid = 1'b0; ia.in_cnt = '0; ia.thresh = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_cnt = '0; ib.thresh = '0; ib.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  ia.in_ready,  1);
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_out_sum",   ia.out_sum,   0);
    check("rst_dropped",   ia.dropped,   0);
    check("rst_b_ready",   ib.in_ready,  1);
    @(posedge clk);
    #1;

    // T1: threshold equal to the sum
    ia.thresh = 8'd15;
    qa.push_back(mk(15, 0, 7, 1));
    send_a(3); send_a(7); send_a(0); send_a(5);
    @(negedge clk);
    check("t1_latency", ia.out_valid, 1);
    @(posedge clk);
    #1;

    // T2: threshold one above the sum
    ia.thresh = 8'd16;
    qa.push_back(mk(15, 0, 7, 0));
    send_a(3); send_a(7); send_a(0); send_a(5);
    @(posedge clk);
    #1;

    // T4: back-pressure with pending input
    ia.out_ready = 1'b0;
    ia.thresh    = 8'd100;
    qa.push_back(mk(100, 10, 40, 1));
    send_a(10); send_a(20); send_a(30); send_a(40);
    ia.in_valid = 1'b1;
    ia.in_cnt   = 6'd55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_in_ready",  ia.in_ready,  0);
      check("t4_valid",     ia.out_valid, 1);
      check("t4_sum_hold",  ia.out_sum,   100);
      check("t4_max_hold",  ia.out_max,   40);
      if (i > 0) check("t4_dropped", ia.dropped, 1);
      @(posedge clk);
      #1;
    end
    ia.out_ready = 1'b1;
    ia.in_cnt    = 6'd9;
    qa.push_back(mk(15, 1, 9, 0));
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    send_a(1); send_a(2); send_a(3);
    @(negedge clk);
    check("t4_next_close", ia.out_valid, 1);
    check("t4_sticky",     ia.dropped,   1);
    @(posedge clk);
    #1;

    // T5: gaps in in_valid
    qa.push_back(mk(20, 2, 8, 0));
    for (int i = 0; i < 7; i++) begin
      ia.in_valid = pat5[i];
      ia.in_cnt   = 6'(c5[i]);
      @(negedge clk);
      check("t5_no_early", ia.out_valid, 0);
      @(posedge clk);
      #1;
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    check("t5_close", ia.out_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_single", ia.out_valid, 0);
    @(posedge clk);
    #1;

    // T3: full-scale samples on the 16-deep window
    ib.thresh = 10'd1008;
    qb.push_back(mk(1008, 63, 63, 1));
    for (int i = 0; i < 15; i++) send_b(6'd63);
    @(negedge clk);
    check("t3_no_early", ib.out_valid, 0);
    send_b(6'd63);
    @(negedge clk);
    check("t3_close", ib.out_valid, 1);
    @(posedge clk);
    #1;

    // T6: async reset mid-window, then clear while holding
    send_a(5); send_a(6);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_sum",   ia.out_sum,   0);
    check("t6_rst_max",   ia.out_max,   0);
    check("t6_rst_valid", ia.out_valid, 0);
    check("t6_rst_drop",  ia.dropped,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_ready", ia.in_ready, 1);
    ia.out_ready = 1'b0;
    ia.thresh    = 8'd4;
    send_a(1); send_a(1); send_a(1); send_a(1);
    @(negedge clk);
    check("t6_valid", ia.out_valid, 1);
    check("t6_sum",   ia.out_sum,   4);
    check("t6_min",   ia.out_min,   1);
    check("t6_max",   ia.out_max,   1);
    check("t6_above", ia.out_above, 1);
    ia.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    check("t6_dropped", ia.dropped, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("t6_clr_valid", ia.out_valid, 0);
    check("t6_clr_drop",  ia.dropped,   0);
    check("t6_clr_sum",   ia.out_sum,   0);
    check("t6_clr_ready", ia.in_ready,  1);

    repeat (3) @(posedge clk);
    #1;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
